hazard_scoreboard: RTL and testbench



---
 rtl/RV32I_definitions_pkg.sv | 18 +
 rtl/hazard_scoreboard_src_decode.sv | 35 +++
 rtl/hazard_scoreboard.sv | 116 +++++++++++
 tb/tb_hazard_scoreboard.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/RV32I_definitions_pkg.sv
// RV32I shared definitions: base opcodes used for source-operand decode and the
// load scoreboard entry type used by hazard_scoreboard.
package RV32I_definitions;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    // One in-flight load: its destination register and whether the slot is live.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_src_decode.sv
// Source-register decode for the IF instruction: which of rs1/rs2 the opcode
// actually reads, so hazards are only raised on real operands.
module hazard_src_decode
    import RV32I_definitions::*;
(
    input  logic [31:0] instruction,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        rs1_used,
    output logic        rs2_used
);

    logic unused_fields;
    assign unused_fields = ^{instruction[31:25], instruction[14:7]};

    assign rs1 = instruction[19:15];
    assign rs2 = instruction[24:20];

    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (instruction[6:0])
            OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR: begin
                rs1_used = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller: load-use stall via a load scoreboard, multi-cycle
// redirect flush, and full freeze on DMEM_busy. HAZARD_PERF_CNT_EN adds perf counters.
module hazard_scoreboard
    import RV32I_definitions::*;
#(
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int LOAD_LATENCY       = 1,
    parameter int FLUSH_CYCLES       = 2
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic [31:0]                   IF_Instruction,
    input  logic                          ID_Mem_rd_en,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rd_addr,
    input  logic                          EX_PC_Branch,
    input  logic                          ID_Jump,
    input  logic                          DMEM_busy,
    output logic                          Stall,
    output logic                          IF_ID_Flush,
    output logic                          EX_Flush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]                   Load_stall_cnt,
    output logic [31:0]                   Flush_cnt
`endif
);

    localparam int SB_DEPTH = LOAD_LATENCY - 1;

    logic [4:0] rs1, rs2;
    logic       rs1_used, rs2_used;
    logic       rs1_live, rs2_live;
    logic [4:0] id_rd;
    logic       id_load_live;
    logic       id_hit;
    logic       sb_hit;
    logic       load_use;
    logic       redirect;
    logic [2:0] flush_cnt_q;

    hazard_src_decode u_src_decode (
        .instruction (IF_Instruction),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_used    (rs1_used),
        .rs2_used    (rs2_used)
    );

    // x0 is hardwired, so a zero source can never depend on a load.
    assign rs1_live     = rs1_used && (rs1 != 5'd0);
    assign rs2_live     = rs2_used && (rs2 != 5'd0);
    assign id_rd        = 5'(ID_Rd_addr);
    assign id_load_live = ID_Mem_rd_en && (ID_Rd_addr != '0);
    assign id_hit       = id_load_live &&
                          ((rs1_live && rs1 == id_rd) || (rs2_live && rs2 == id_rd));

    generate
        if (SB_DEPTH > 0) begin : g_sb
            sb_entry_t sb_q [SB_DEPTH];

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    for (int k = 0; k < SB_DEPTH; k++) sb_q[k] <= '0;
                end else if (!DMEM_busy) begin
                    sb_q[0] <= '{valid: id_load_live && !IF_ID_Flush, rd: id_rd};
                    for (int k = 1; k < SB_DEPTH; k++) sb_q[k] <= sb_q[k-1];
                end
            end

            always_comb begin
                sb_hit = 1'b0;
                for (int k = 0; k < SB_DEPTH; k++) begin
                    if (sb_q[k].valid &&
                        ((rs1_live && rs1 == sb_q[k].rd) || (rs2_live && rs2 == sb_q[k].rd)))
                        sb_hit = 1'b1;
                end
            end
        end else begin : g_no_sb
            assign sb_hit = 1'b0;
        end
    endgenerate

    assign load_use = id_hit || sb_hit;
    assign redirect = EX_PC_Branch || ID_Jump;

    // A fresh redirect reloads rather than extends, so overlapping redirects never stack.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flush_cnt_q <= 3'd0;
        end else if (!DMEM_busy) begin
            if (redirect)
                flush_cnt_q <= 3'(FLUSH_CYCLES - 1);
            else if (flush_cnt_q != 3'd0)
                flush_cnt_q <= flush_cnt_q - 3'd1;
        end
    end

    assign IF_ID_Flush = redirect || (flush_cnt_q != 3'd0);
    assign EX_Flush    = EX_PC_Branch;
    assign Stall       = DMEM_busy || (load_use && !IF_ID_Flush);

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Load_stall_cnt <= 32'd0;
            Flush_cnt      <= 32'd0;
        end else if (!DMEM_busy) begin
            if (load_use && !IF_ID_Flush && Load_stall_cnt != 32'hFFFF_FFFF)
                Load_stall_cnt <= Load_stall_cnt + 32'd1;
            if (redirect && Flush_cnt != 32'hFFFF_FFFF)
                Flush_cnt <= Flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: three parameterisations share one input
// set; each scenario checks the instance it targets. Honors HAZARD_PERF_CNT_EN.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] if_instr;
    logic        id_mem_rd_en;
    logic [4:0]  id_rd_addr;
    logic        ex_pc_branch;
    logic        id_jump;
    logic        dmem_busy;

    logic stall_a, iflush_a, exflush_a;
    logic stall_b, iflush_b, exflush_b;
    logic stall_c, iflush_c, exflush_c;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lsc_a, fc_a, lsc_b, fc_b, lsc_c, fc_c;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // a: LOAD_LATENCY=1 FLUSH_CYCLES=2; b: 3/3; c: 2/2
    hazard_scoreboard #(.REGFILE_ADDR_WIDTH(5), .LOAD_LATENCY(1), .FLUSH_CYCLES(2)) u_a (
        .Clk(clk), .Reset_n(reset_n), .IF_Instruction(if_instr), .ID_Mem_rd_en(id_mem_rd_en),
        .ID_Rd_addr(id_rd_addr), .EX_PC_Branch(ex_pc_branch), .ID_Jump(id_jump),
        .DMEM_busy(dmem_busy), .Stall(stall_a), .IF_ID_Flush(iflush_a), .EX_Flush(exflush_a)
`ifdef HAZARD_PERF_CNT_EN
        , .Load_stall_cnt(lsc_a), .Flush_cnt(fc_a)
`endif
    );

    hazard_scoreboard #(.REGFILE_ADDR_WIDTH(5), .LOAD_LATENCY(3), .FLUSH_CYCLES(3)) u_b (
        .Clk(clk), .Reset_n(reset_n), .IF_Instruction(if_instr), .ID_Mem_rd_en(id_mem_rd_en),
        .ID_Rd_addr(id_rd_addr), .EX_PC_Branch(ex_pc_branch), .ID_Jump(id_jump),
        .DMEM_busy(dmem_busy), .Stall(stall_b), .IF_ID_Flush(iflush_b), .EX_Flush(exflush_b)
`ifdef HAZARD_PERF_CNT_EN
        , .Load_stall_cnt(lsc_b), .Flush_cnt(fc_b)
`endif
    );

    hazard_scoreboard #(.REGFILE_ADDR_WIDTH(5), .LOAD_LATENCY(2), .FLUSH_CYCLES(2)) u_c (
        .Clk(clk), .Reset_n(reset_n), .IF_Instruction(if_instr), .ID_Mem_rd_en(id_mem_rd_en),
        .ID_Rd_addr(id_rd_addr), .EX_PC_Branch(ex_pc_branch), .ID_Jump(id_jump),
        .DMEM_busy(dmem_busy), .Stall(stall_c), .IF_ID_Flush(iflush_c), .EX_Flush(exflush_c)
`ifdef HAZARD_PERF_CNT_EN
        , .Load_stall_cnt(lsc_c), .Flush_cnt(fc_c)
`endif
    );

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, 5'b0, 7'b1100011};
    endfunction

    // lui with an immediate whose bits land on field [19:15] = x9
    function automatic logic [31:0] enc_lui_x9();
        return {20'h00048, 5'd9, 7'b0110111};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_instr     = 32'h0000_0013;
        id_mem_rd_en = 1'b0;
        id_rd_addr   = 5'd0;
        ex_pc_branch = 1'b0;
        id_jump      = 1'b0;
        dmem_busy    = 1'b0;
    endtask

    task automatic apply_reset();
        step();
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        step();
        idle_inputs();
        reset_n = 1'b0;
        #1;
        checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL rst_stall_idle: got %b want 0", stall_a); end
        checks++; if (iflush_b !== 1'b0) begin errors++; $display("FAIL rst_iflush_idle: got %b want 0", iflush_b); end
        dmem_busy = 1'b1;
        #1;
        checks++; if (stall_c !== 1'b1) begin errors++; $display("FAIL rst_stall_busy: got %b want 1", stall_c); end
        dmem_busy    = 1'b0;
        ex_pc_branch = 1'b1;
        #1;
        checks++; if (iflush_a !== 1'b1) begin errors++; $display("FAIL rst_iflush_redirect: got %b want 1", iflush_a); end
        checks++; if (exflush_a !== 1'b1) begin errors++; $display("FAIL rst_exflush: got %b want 1", exflush_a); end
        ex_pc_branch = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        checks++; if (iflush_b !== 1'b0) begin errors++; $display("FAIL rst_after_iflush: got %b want 0", iflush_b); end
        checks++; if (stall_b !== 1'b0) begin errors++; $display("FAIL rst_after_stall: got %b want 0", stall_b); end
`ifdef HAZARD_PERF_CNT_EN
        checks++; if (lsc_a !== 32'd0) begin errors++; $display("FAIL rst_lsc: got %0d want 0", lsc_a); end
        checks++; if (fc_a !== 32'd0) begin errors++; $display("FAIL rst_fc: got %0d want 0", fc_a); end
`endif
    endtask

    task automatic test_load_use_l1();
        apply_reset();
        step();
        id_mem_rd_en = 1'b1; id_rd_addr = 5'd5; if_instr = enc_add(5'd7, 5'd5, 5'd6);
        #1;
        checks++; if (stall_a !== 1'b1) begin errors++; $display("FAIL l1_stall_c0: got %b want 1", stall_a); end
        step();
        id_mem_rd_en = 1'b0; id_rd_addr = 5'd0;
        #1;
        checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL l1_stall_c1: got %b want 0", stall_a); end
        apply_reset();
        step();
        id_mem_rd_en = 1'b1; id_rd_addr = 5'd0; if_instr = enc_add(5'd7, 5'd0, 5'd6);
        #1;
        checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL l1_x0_stall: got %b want 0", stall_a); end
    endtask

    task automatic test_load_use_l3();
        logic [3:0] exp_seq;
        exp_seq = 4'b0111;
        apply_reset();
        step();
        id_mem_rd_en = 1'b1; id_rd_addr = 5'd9; if_instr = enc_beq(5'd9, 5'd1);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) begin
                step();
                id_mem_rd_en = 1'b0; id_rd_addr = 5'd0;
            end
            #1;
            checks++;
            if (stall_b !== exp_seq[i]) begin
                errors++; $display("FAIL l3_stall_c%0d: got %b want %b", i, stall_b, exp_seq[i]);
            end
        end
        apply_reset();
        step();
        id_mem_rd_en = 1'b1; id_rd_addr = 5'd9; if_instr = enc_lui_x9();
        #1;
        checks++; if (stall_b !== 1'b0) begin errors++; $display("FAIL l3_lui_c0: got %b want 0", stall_b); end
        step();
        id_mem_rd_en = 1'b0; id_rd_addr = 5'd0;
        #1;
        checks++; if (stall_b !== 1'b0) begin errors++; $display("FAIL l3_lui_c1: got %b want 0", stall_b); end
    endtask

    task automatic test_branch_flush();
        apply_reset();
        step();
        ex_pc_branch = 1'b1;
        id_mem_rd_en = 1'b1; id_rd_addr = 5'd5; if_instr = enc_add(5'd7, 5'd5, 5'd6);
        #1;
        checks++; if (exflush_a !== 1'b1) begin errors++; $display("FAIL br_exflush_c0: got %b want 1", exflush_a); end
        checks++; if (iflush_a !== 1'b1) begin errors++; $display("FAIL br_iflush_c0: got %b want 1", iflush_a); end
        checks++; if (stall_a !== 1'b0) begin errors++; $display("FAIL br_stall_masked: got %b want 0", stall_a); end
        step();
        ex_pc_branch = 1'b0; id_mem_rd_en = 1'b0; id_rd_addr = 5'd0;
        #1;
        checks++; if (exflush_a !== 1'b0) begin errors++; $display("FAIL br_exflush_c1: got %b want 0", exflush_a); end
        checks++; if (iflush_a !== 1'b1) begin errors++; $display("FAIL br_iflush_c1: got %b want 1", iflush_a); end
        step();
        checks++; if (iflush_a !== 1'b0) begin errors++; $display("FAIL br_iflush_c2: got %b want 0", iflush_a); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_seq;
        exp_seq = 5'b01111;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            id_jump = (i < 2);
            #1;
            checks++;
            if (iflush_b !== exp_seq[i]) begin
                errors++; $display("FAIL jmp2_iflush_c%0d: got %b want %b", i, iflush_b, exp_seq[i]);
            end
        end
    endtask

    task automatic test_dmem_busy();
        logic [5:0] exp_seq;
        exp_seq = 6'b011111;
        apply_reset();
        step();
        id_mem_rd_en = 1'b1; id_rd_addr = 5'd5; if_instr = enc_add(5'd7, 5'd5, 5'd6);
        for (int i = 0; i < 6; i++) begin
            if (i != 0) begin
                step();
                // an unrelated load sits in ID while frozen; it must not displace x5
                dmem_busy    = (i <= 3);
                id_mem_rd_en = (i <= 3);
                id_rd_addr   = (i <= 3) ? 5'd12 : 5'd0;
            end
            #1;
            checks++;
            if (stall_c !== exp_seq[i]) begin
                errors++; $display("FAIL busy_stall_c%0d: got %b want %b", i, stall_c, exp_seq[i]);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        apply_reset();
        step();
        ex_pc_branch = 1'b1;
        step();
        ex_pc_branch = 1'b0;
        #1;
        checks++; if (iflush_a !== 1'b1) begin errors++; $display("FAIL rmf_iflush_pre: got %b want 1", iflush_a); end
        reset_n = 1'b0;
        #1;
        checks++; if (iflush_a !== 1'b0) begin errors++; $display("FAIL rmf_iflush_rst: got %b want 0", iflush_a); end
`ifdef HAZARD_PERF_CNT_EN
        checks++; if (fc_a !== 32'd0) begin errors++; $display("FAIL rmf_fc: got %0d want 0", fc_a); end
        checks++; if (lsc_a !== 32'd0) begin errors++; $display("FAIL rmf_lsc: got %0d want 0", lsc_a); end
`endif
        step();
        reset_n = 1'b1;
        step();
        checks++; if (iflush_a !== 1'b0) begin errors++; $display("FAIL rmf_iflush_post: got %b want 0", iflush_a); end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_counters();
        apply_reset();
        step();
        id_mem_rd_en = 1'b1; id_rd_addr = 5'd5; if_instr = enc_add(5'd7, 5'd5, 5'd6);
        step();
        id_mem_rd_en = 1'b0; id_rd_addr = 5'd0;
        #1;
        checks++; if (lsc_a !== 32'd1) begin errors++; $display("FAIL perf_lsc: got %0d want 1", lsc_a); end
        ex_pc_branch = 1'b1;
        step();
        ex_pc_branch = 1'b0;
        #1;
        checks++; if (fc_a !== 32'd1) begin errors++; $display("FAIL perf_fc: got %0d want 1", fc_a); end
        ex_pc_branch = 1'b1; dmem_busy = 1'b1;
        step();
        ex_pc_branch = 1'b0; dmem_busy = 1'b0;
        #1;
        checks++; if (fc_a !== 32'd1) begin errors++; $display("FAIL perf_fc_busy: got %0d want 1", fc_a); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_load_use_l1();
        test_load_use_l3();
        test_branch_flush();
        test_back_to_back();
        test_dmem_busy();
        test_reset_mid_flush();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
